mem_wb_pipe_stage: RTL and testbench

Parametrised MEM/WB pipeline register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, a forwarding tap and a saturating stall counter. It sits between the memory-stage result mux and the write-back stage. It replaces the plain 32-bit data latch with a stage that can absorb one cycle of write-back back-pressure without losing a result. Each stage entry carries a data word, a destination register index and a register-write enable.

---
 rtl/mem_wb_pipe_stage.sv | 107 ++++++++++
 tb/tb_mem_wb_pipe_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_stage.sv
// rtl/mem_wb_pipe_stage.sv - MEM/WB pipeline register with two-entry skid buffer, flush, forwarding tap and stall counter
module mem_wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] h_data, s_data;
    logic [RD_W-1:0]   h_rd, s_rd;
    logic              h_wen, s_wen;
    logic              accept, drain;

    // Handshake flags come from registered state only, so no in->out combinational path.
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    assign out_data  = h_data;
    assign out_rd    = h_rd;
    assign out_wen   = out_valid & h_wen;
    assign fwd_valid = out_wen & (h_rd != '0);
    assign fwd_rd    = h_rd;
    assign fwd_data  = h_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            h_data    <= '0;
            h_rd      <= '0;
            h_wen     <= 1'b0;
            s_data    <= '0;
            s_rd      <= '0;
            s_wen     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            // Flush wins: stale data may remain in H/S, but out_wen is masked by out_valid.
            if (flush) begin
                state <= ST_EMPTY;
            end else begin
                unique case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            state  <= ST_ONE;
                            h_data <= in_data;
                            h_rd   <= in_rd;
                            h_wen  <= in_wen;
                        end
                    end
                    ST_ONE: begin
                        if (accept && drain) begin
                            h_data <= in_data;
                            h_rd   <= in_rd;
                            h_wen  <= in_wen;
                        end else if (accept) begin
                            state  <= ST_TWO;
                            s_data <= in_data;
                            s_rd   <= in_rd;
                            s_wen  <= in_wen;
                        end else if (drain) begin
                            state <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (drain) begin
                            state  <= ST_ONE;
                            h_data <= s_data;
                            h_rd   <= s_rd;
                            h_wen  <= s_wen;
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb/tb_mem_wb_pipe_stage.sv - scoreboard bench for mem_wb_pipe_stage
module tb_mem_wb_pipe_stage;

    localparam int DATA_W  = 32;
    localparam int RD_W    = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_wen;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_wen;
    logic              fwd_valid;
    logic [RD_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  stall_cnt;

    mem_wb_pipe_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [RD_W-1:0]   rd;
        logic              wen;
    } ent_t;

    ent_t exp_q[$];
    int   m_cnt = 0;
    bit   last_acc = 0;
    bit   m_valid, m_ready;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a 2-deep FIFO, drain before accept, flush empties it.
    always @(posedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            m_cnt    = 0;
            last_acc = 0;
        end else begin
            m_valid  = exp_q.size() > 0;
            m_ready  = exp_q.size() < 2;
            last_acc = in_valid && m_ready;
            if (m_valid && !out_ready && !flush && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_valid && out_ready) void'(exp_q.pop_front());
                if (last_acc) exp_q.push_back('{d: in_data, rd: in_rd, wen: in_wen});
            end
        end
    end

    always @(negedge reset_n) begin
        exp_q.delete();
        m_cnt    = 0;
        last_acc = 0;
    end

    // Monitor: compares every presented output against the head of the expected queue.
    always @(negedge clock) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
        if (out_valid && exp_q.size() > 0) begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
            chk("out_wen", {31'd0, out_wen}, {31'd0, exp_q[0].wen});
            chk("fwd_valid", {31'd0, fwd_valid},
                {31'd0, exp_q[0].wen && (exp_q[0].rd != 0)});
            chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, exp_q[0].rd});
            chk("fwd_data", fwd_data, exp_q[0].d);
        end else begin
            chk("out_wen_idle", {31'd0, out_wen}, 32'd0);
            chk("fwd_valid_idle", {31'd0, fwd_valid}, 32'd0);
        end
    end

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                         input bit w, input bit ordy, input bit fl);
        @(posedge clock);
        #1;
        in_valid  = v;
        in_data   = d;
        in_rd     = rd;
        in_wen    = w;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_wen"}, {31'd0, out_wen}, 32'd0);
        chk({tag, "_fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
        chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rd     = '0;
        in_wen    = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Streaming at full throughput
        drive(1, 32'h11, 5'd1, 1, 1, 0);
        drive(1, 32'h22, 5'd2, 1, 1, 0);
        drive(1, 32'h33, 5'd3, 1, 1, 0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        chk("stream_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // Back-pressure: A0 into H, A1 into S, A2 held upstream
        drive(1, 32'hA0, 5'd4, 1, 0, 0);
        drive(1, 32'hA1, 5'd5, 1, 0, 0);
        drive(1, 32'hA2, 5'd6, 1, 0, 0);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        drive(1, 32'hA2, 5'd6, 1, 0, 0);
        drive(1, 32'hA2, 5'd6, 1, 1, 0);
        drive(1, 32'hA2, 5'd6, 1, 1, 0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);

        // Flush in TWO with a simultaneous offer that must vanish
        drive(1, 32'h01, 5'd1, 1, 0, 0);
        drive(1, 32'h02, 5'd2, 1, 0, 0);
        drive(1, 32'hBB, 5'd9, 1, 0, 1);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_wen", {31'd0, out_wen}, 32'd0);
        chk("flush_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        drive(0, 32'h0, 5'd0, 0, 1, 0);

        // Forwarding tap
        drive(1, 32'hFF, 5'd0, 1, 0, 0);
        drive(0, 32'h0, 5'd0, 0, 0, 0);
        chk("fwd_rd0", {31'd0, fwd_valid}, 32'd0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        drive(1, 32'h77, 5'd7, 0, 0, 0);
        drive(0, 32'h0, 5'd0, 0, 0, 0);
        chk("fwd_wen0", {31'd0, fwd_valid}, 32'd0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        drive(1, 32'h1234, 5'd7, 1, 0, 0);
        drive(0, 32'h0, 5'd0, 0, 0, 0);
        chk("fwd_hit_valid", {31'd0, fwd_valid}, 32'd1);
        chk("fwd_hit_rd", {27'd0, fwd_rd}, 32'd7);
        chk("fwd_hit_data", fwd_data, 32'h1234);

        // Saturation of the stall counter
        for (int i = 0; i < 20; i++) drive(0, 32'h0, 5'd0, 0, 0, 0);
        chk("stall_saturated", {28'd0, stall_cnt}, CNT_MAX);

        // Asynchronous reset between edges while in TWO
        drive(1, 32'h66, 5'd6, 1, 0, 0);
        drive(0, 32'h0, 5'd0, 0, 0, 0);
        chk("pre_reset_two", {31'd0, in_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        reset_n = 1'b1;
        drive(1, 32'h77, 5'd4, 1, 1, 0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);

        // Randomised traffic with a well-behaved upstream that holds until accepted
        for (int i = 0; i < 600; i++) begin
            @(posedge clock);
            #1;
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
                in_rd    = 5'($urandom_range(0, 7));
                in_wen   = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
        end
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        drive(0, 32'h0, 5'd0, 0, 1, 0);
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
